// File: rtl/branch_pc_unit.sv
// PC / next-PC stage: selects PC+4, branch/JAL or JALR target, hands the PC
// to fetch over a valid/ready handshake, traps on misaligned redirects.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cmp_result,
  input  logic             branch,
  input  logic             jump,
  input  logic             jalr,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  input  logic             stall,
  input  logic             fetch_ready,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             taken,
  output logic             trap,
  output logic [31:0]      trap_addr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic        run, adv, cond, misal, br_only;
  logic [31:0] target;
  logic        unused_cmp;

  // only the condition bit of the comparator word matters
  assign unused_cmp = ^cmp_result[31:1];

  assign run         = (state == RUN);
  assign fetch_valid = run;
  assign adv         = run & fetch_valid & fetch_ready & ~stall;
  assign cond        = branch & cmp_result[0];
  assign taken       = run & (jalr | jump | cond);
  assign pc_plus4    = pc + 32'd4;
  assign misal       = taken & (target[1:0] != 2'b00);
  assign br_only     = branch & ~jump & ~jalr;

  always_comb begin
    target = pc_plus4;
    if (jalr)
      target = (rs1 + imm) & 32'hFFFF_FFFE;
    else if (jump | cond)
      target = pc + imm;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (adv && misal) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      trap           <= 1'b0;
      trap_addr      <= 32'h0;
      br_count       <= '0;
      br_taken_count <= '0;
    end else begin
      state <= state_nxt;
      if (adv) begin
        // a misaligned redirect freezes pc and records the bad target
        if (misal) begin
          trap      <= 1'b1;
          trap_addr <= target;
        end else begin
          pc <= target;
        end
        if (br_only) begin
          br_count <= br_count + CNT_W'(1);
          if (cmp_result[0])
            br_taken_count <= br_taken_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: boot, branches, JALR, stall/handshake,
// misaligned trap, async reset recovery, wrap-around and redirect priority.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmp_result, imm, rs1;
  logic        branch, jump, jalr, stall, fetch_ready;
  logic [31:0] pc, pc_plus4, trap_addr;
  logic        fetch_valid, taken, trap;
  logic [15:0] br_count, br_taken_count;

  int vectors = 0;
  int fails   = 0;

  branch_pc_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmp_result(cmp_result), .branch(branch), .jump(jump),
    .jalr(jalr), .imm(imm), .rs1(rs1), .stall(stall), .fetch_ready(fetch_ready),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .taken(taken),
    .trap(trap), .trap_addr(trap_addr), .br_count(br_count),
    .br_taken_count(br_taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    branch = 0; jump = 0; jalr = 0; stall = 0;
    imm = 0; rs1 = 0; cmp_result = 0;
  endtask

  initial begin
    rst = 1; fetch_ready = 1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'h0);
    chk("rst_trap", 32'(trap), 32'h0);
    chk("rst_taddr", trap_addr, 32'h0);
    chk("rst_brc", 32'(br_count), 32'h0);
    chk("rst_brt", 32'(br_taken_count), 32'h0);

    // boot: one cycle with fetch_valid low, then 0,4,8
    @(negedge clk); rst = 0;
    #1 chk("boot_fv0", 32'(fetch_valid), 32'h0);
    tick(); chk("boot_fv1", 32'(fetch_valid), 32'h1);
    chk("seq_pc0", pc, 32'h0);
    tick(); chk("seq_pc4", pc, 32'h4);
    tick(); chk("seq_pc8", pc, 32'h8);

    // taken branch at 0x8
    branch = 1; imm = 32'h10; cmp_result = 32'h1;
    #1 chk("br_taken_comb", 32'(taken), 32'h1);
    tick(); chk("br_t_pc", pc, 32'h18);
    chk("br_t_cnt", 32'(br_count), 32'h1);
    chk("br_t_tcnt", 32'(br_taken_count), 32'h1);

    // not-taken branch: upper comparator bits set but bit0 clear
    cmp_result = 32'hFFFF_FFFE;
    #1 chk("br_nt_comb", 32'(taken), 32'h0);
    tick(); chk("br_nt_pc", pc, 32'h1C);
    chk("br_nt_cnt", 32'(br_count), 32'h2);
    chk("br_nt_tcnt", 32'(br_taken_count), 32'h1);

    // stall beats ready; a pending taken branch must not be counted
    stall = 1; cmp_result = 32'h1;
    repeat (3) tick();
    chk("stall_pc", pc, 32'h1C);
    chk("stall_cnt", 32'(br_count), 32'h2);
    chk("stall_tcnt", 32'(br_taken_count), 32'h1);

    // ready low for two cycles with a changing redirect, then accept plain
    clr(); fetch_ready = 0; jump = 1; imm = 32'h40;
    tick(); chk("nrdy_pc1", pc, 32'h1C);
    imm = 32'h80;
    tick(); chk("nrdy_pc2", pc, 32'h1C);
    chk("nrdy_fv", 32'(fetch_valid), 32'h1);
    jump = 0; imm = 0; fetch_ready = 1;
    tick(); chk("rdy_pc", pc, 32'h20);
    tick(); chk("rdy_once", pc, 32'h24);

    // JALR: (0x101 + 3) & ~1 = 0x104
    jalr = 1; rs1 = 32'h101; imm = 32'h3;
    #1 chk("jalr_link", pc_plus4, 32'h28);
    chk("jalr_taken", 32'(taken), 32'h1);
    tick(); chk("jalr_pc", pc, 32'h104);

    // misaligned jump: 0x104 + 6 = 0x10A
    clr(); jump = 1; imm = 32'h6;
    tick();
    chk("mis_trap", 32'(trap), 32'h1);
    chk("mis_taddr", trap_addr, 32'h10A);
    chk("mis_pc", pc, 32'h104);
    chk("mis_fv", 32'(fetch_valid), 32'h0);
    chk("halt_taken", 32'(taken), 32'h0);
    tick(); chk("halt_pc", pc, 32'h104);

    // async reset mid-cycle
    #2 rst = 1;
    #1 chk("arst_trap", 32'(trap), 32'h0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_fv", 32'(fetch_valid), 32'h0);
    chk("arst_brc", 32'(br_count), 32'h0);
    clr();
    @(negedge clk); rst = 0;
    tick(); chk("reboot_pc", pc, 32'h0);

    // wrap-around: jump to 0xFFFF_FFFC, then sequential to 0
    jalr = 1; rs1 = 32'hFFFF_FFFC;
    tick(); chk("wrap_hi", pc, 32'hFFFF_FFFC);
    clr();
    tick(); chk("wrap_zero", pc, 32'h0);

    // all three redirects at once: JALR wins, not counted as a branch
    branch = 1; jump = 1; jalr = 1; cmp_result = 32'h1; rs1 = 32'h200; imm = 32'h0;
    tick(); chk("prio_pc", pc, 32'h200);
    chk("prio_cnt", 32'(br_count), 32'h0);
    chk("prio_tcnt", 32'(br_taken_count), 32'h0);
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
